prbs_bit_source: RTL and testbench
==================================

# prbs_bit_source

Synthesizable, parametrised serial test-data source for the spread-spectrum transmit chain. Generates words (PRBS, zero, alternating or fixed pattern), serializes them MSB-first at one bit per `CHIP_RATIO` chip clocks, and drives `in_data` of the coder. It replaces the two-clock file-driven byte feeder with a single chip clock, a frame counter and an optional CRC-8 trailer.

## Interface
- `DATA_W`, 8: word width, 2..16.
- `FRAME_LEN`, 400: words per frame, ≥1.
- `CHIP_RATIO`, 31: chip-clock cycles per bit, ≥2.
- `SEED`, 16'hACE1: LFSR seed, nonzero.
- `clk31` in 1: chip clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `send_ena` in 1: global enable; low aborts to IDLE.
- `insource_ena` in 1: coder request; low pauses output.
- `loop` in 1: 1 = restart frame after completion, 0 = stop in DONE.
- `mode` in 2: 0 PRBS, 1 all-zero, 2 alternating (MSB 0: 0x55 for DATA_W=8), 3 fixed `pattern`.
- `pattern` in DATA_W: word used in mode 3.
- `in_data` out 1: serial bit to coder.
- `bit_strobe` out 1: one-cycle pulse on the cycle a new bit appears.
- `word_start` out 1: one-cycle pulse with the MSB of each data word.
- `frame_done` out 1: one-cycle pulse after the last bit of a frame.
- `word_cnt` out $clog2(FRAME_LEN+1): index of word being sent (0-based).
- `busy` out 1: high in RUN/CRC.

## Operation
- States: IDLE, RUN, CRC (macro only), DONE.
- IDLE: on `send_ena & insource_ena` -> RUN; LFSR := SEED, word_cnt := 0, CRC := 0x00, load word 0.
- Word load: mode sampled at each load. PRBS word = lfsr[15 -: DATA_W], then LFSR steps once: fb = l[15]^l[13]^l[12]^l[10], l := {l[14:0], fb}. SEED 0xACE1, DATA_W 8 -> words 0xAC, 0x59, ...
- Chip counter 0..CHIP_RATIO-1 advances while running; on wrap the shift register shifts left, next bit presented, bit_strobe pulses.
- After DATA_W bits: word_cnt+1 and next word loaded, unless word_cnt = FRAME_LEN-1 -> end of frame.
- End of frame: CRC if macro on, else frame_done pulse and RUN (loop=1, reseed, word_cnt 0, word_start) or DONE (loop=0).
- DONE: in_data 0, busy 0; exit to IDLE only when send_ena low.
- Pause: `insource_ena` low in RUN/CRC freezes chip counter, shift register, LFSR, CRC, in_data; resumes at same chip count.
- Abort: `send_ena` low in any state -> IDLE next cycle; in_data 0, all counters cleared, no frame_done.
- send_ena and insource_ena both deasserted same cycle: abort wins.

## Timing
- Reset values: in_data 0, bit_strobe 0, word_start 0, frame_done 0, word_cnt 0, busy 0, state IDLE, LFSR SEED, CRC 0x00.
- Start latency: enables high at edge N -> in_data = word0 MSB, bit_strobe=1, word_start=1, busy=1 after edge N+1.
- Each bit held exactly CHIP_RATIO cycles; frame length (no CRC) = FRAME_LEN·DATA_W·CHIP_RATIO cycles plus pauses.
- frame_done asserted in the cycle after the last bit's final chip; in loop mode this coincides with word_start of the next frame (no gap).
- All outputs registered.

## Configuration
- `PRBS_SRC_CRC8_EN` defined: CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no xorout) accumulates every data bit at its bit_strobe; after the last data bit, state CRC emits 8 CRC bits MSB-first at the same bit rate (bit_strobe pulses, word_start does not, word_cnt holds FRAME_LEN-1); frame_done after the 8th CRC bit.
- Undefined: no CRC state or logic; frame_done directly after last data bit.

## Test plan
- DATA_W 8, FRAME_LEN 2, CHIP_RATIO 31, mode 0, loop 0 -> serial bytes 0xAC, 0x59; each bit 31 cycles; frame_done once at cycle 496 after start; DONE, busy 0.
- Mode 3, pattern 0x01, FRAME_LEN 1, macro on -> bits 00000001 then CRC 0x07 (00000111); frame_done after 16 bits.
- Mode 1, FRAME_LEN 4, loop 1 -> all-zero output, frame_done every 992 cycles, word_start with no gap, word_cnt 0..3 repeating; second frame identical.
- insource_ena low for 50 cycles at chip 10 of bit 3 -> in_data held, bit 3 lasts 81 cycles total, following bits unchanged.
- send_ena low mid-word -> IDLE next cycle, in_data 0, no frame_done; restart reproduces 0xAC first.
- rst pulse mid-frame (async, between edges) -> outputs zero immediately; after release, sequence restarts from SEED.

Source files
------------

// File: rtl/prbs_bit_source.sv
// Serial PRBS/pattern test-data source: words go out MSB-first, one bit per CHIP_RATIO chip clocks.
// Define PRBS_SRC_CRC8_EN to append a CRC-8 (poly 0x07) trailer to every frame.
module prbs_bit_source #(
  parameter int          DATA_W     = 8,
  parameter int          FRAME_LEN  = 400,
  parameter int          CHIP_RATIO = 31,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         WC_W       = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk31,
  input  logic              rst,
  input  logic              send_ena,
  input  logic              insource_ena,
  input  logic              loop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  output logic              in_data,
  output logic              bit_strobe,
  output logic              word_start,
  output logic              frame_done,
  output logic [WC_W-1:0]   word_cnt,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CC_W = $clog2(CHIP_RATIO);
  localparam int BC_W = ($clog2(DATA_W) > 3) ? $clog2(DATA_W) : 3;
  localparam logic [CC_W-1:0] CHIP_LAST = CC_W'(CHIP_RATIO - 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
  localparam logic [WC_W-1:0] WC_LAST   = WC_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef PRBS_SRC_CRC8_EN
    CRC  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] alt_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W; i++) w[i] = ((DATA_W - 1 - i) % 2) == 1;
    return w;
  endfunction

  localparam logic [DATA_W-1:0] ALT_WORD = alt_word();

  function automatic logic [DATA_W-1:0] make_word(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] pat,
                                                  input logic [15:0] l);
    case (m)
      2'd0:    return l[15 -: DATA_W];
      2'd1:    return '0;
      2'd2:    return ALT_WORD;
      default: return pat;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

`ifdef PRBS_SRC_CRC8_EN
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction
`endif

  state_t            state;
  logic [CC_W-1:0]   chip_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic [15:0]       lfsr;
`ifdef PRBS_SRC_CRC8_EN
  logic [7:0]        crc;
  logic [7:0]        crc_base;
  logic              crc_shift;
`endif

  // insource_ena is the coder's ready: while low in RUN/CRC nothing advances.
  // bit_strobe marks the cycle a new bit appears on in_data.
  logic              active, wrap, data_last, word_last, start;
  logic              shift_bit, load_mid, data_end, frame_end, do_load, fresh;
  logic [15:0]       src_lfsr, ld_lfsr;
  logic [DATA_W-1:0] ld_word;

`ifdef PRBS_SRC_CRC8_EN
  assign active = ((state == RUN) || (state == CRC)) && insource_ena;
`else
  assign active = (state == RUN) && insource_ena;
`endif
  assign wrap      = active && (chip_cnt == CHIP_LAST);
  assign data_last = (bit_cnt == BIT_LAST);
  assign word_last = (word_cnt == WC_LAST);
  assign start     = (state == IDLE) && insource_ena;
  assign shift_bit = wrap && (state == RUN) && !data_last;
  assign load_mid  = wrap && (state == RUN) && data_last && !word_last;
  assign data_end  = wrap && (state == RUN) && data_last && word_last;
`ifdef PRBS_SRC_CRC8_EN
  assign crc_shift = wrap && (state == CRC) && (bit_cnt != BC_W'(7));
  assign frame_end = wrap && (state == CRC) && (bit_cnt == BC_W'(7));
`else
  assign frame_end = data_end;
`endif
  assign do_load = start || load_mid || (frame_end && loop);

  // A load is the first word of a frame when leaving IDLE or wrapping after the last word.
  assign fresh    = (state == IDLE) || word_last;
  assign src_lfsr = fresh ? SEED : lfsr;
  assign ld_word  = make_word(mode, pattern, src_lfsr);
  assign ld_lfsr  = (mode == 2'd0) ? lfsr_step(src_lfsr) : src_lfsr;
`ifdef PRBS_SRC_CRC8_EN
  assign crc_base = fresh ? 8'h00 : crc;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk31 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      chip_cnt   <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      lfsr       <= SEED;
      word_cnt   <= '0;
      in_data    <= 1'b0;
      bit_strobe <= 1'b0;
      word_start <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef PRBS_SRC_CRC8_EN
      crc        <= 8'h00;
`endif
    end else if (!send_ena) begin
      state      <= IDLE;
      chip_cnt   <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      lfsr       <= SEED;
      word_cnt   <= '0;
      in_data    <= 1'b0;
      bit_strobe <= 1'b0;
      word_start <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef PRBS_SRC_CRC8_EN
      crc        <= 8'h00;
`endif
    end else begin
      bit_strobe <= 1'b0;
      word_start <= 1'b0;
      frame_done <= 1'b0;
      if (active) chip_cnt <= wrap ? '0 : chip_cnt + 1'b1;
      if (do_load) begin
        state      <= RUN;
        busy       <= 1'b1;
        chip_cnt   <= '0;
        bit_cnt    <= '0;
        word_cnt   <= fresh ? '0 : word_cnt + 1'b1;
        sreg       <= ld_word;
        lfsr       <= ld_lfsr;
        in_data    <= ld_word[DATA_W-1];
        bit_strobe <= 1'b1;
        word_start <= 1'b1;
`ifdef PRBS_SRC_CRC8_EN
        crc        <= crc_step(crc_base, ld_word[DATA_W-1]);
`endif
      end else if (shift_bit) begin
        bit_cnt    <= bit_cnt + 1'b1;
        sreg       <= sreg << 1;
        in_data    <= sreg[DATA_W-2];
        bit_strobe <= 1'b1;
`ifdef PRBS_SRC_CRC8_EN
        crc        <= crc_step(crc, sreg[DATA_W-2]);
      end else if (data_end) begin
        // CRC already holds every data bit; it now doubles as the trailer shift register.
        state      <= CRC;
        bit_cnt    <= '0;
        in_data    <= crc[7];
        bit_strobe <= 1'b1;
      end else if (crc_shift) begin
        bit_cnt    <= bit_cnt + 1'b1;
        crc        <= crc << 1;
        in_data    <= crc[6];
        bit_strobe <= 1'b1;
`endif
      end else if (frame_end) begin
        state   <= DONE;
        busy    <= 1'b0;
        in_data <= 1'b0;
      end
      if (frame_end) frame_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs_bit_source.sv
// Directed bench for prbs_bit_source (DATA_W 8, FRAME_LEN 2, CHIP_RATIO 31); CRC trailer checked when PRBS_SRC_CRC8_EN is defined.
module tb_prbs_bit_source;

  localparam int CR = 31;
`ifdef PRBS_SRC_CRC8_EN
  localparam int FB = 24;
`else
  localparam int FB = 16;
`endif
  localparam int FC = FB * CR;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic       clk31 = 1'b0;
  logic       rst = 1'b1;
  logic       send_ena = 1'b0;
  logic       insource_ena = 1'b0;
  logic       loop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] pattern = 8'h00;
  logic       in_data, bit_strobe, word_start, frame_done, busy;
  logic [1:0] word_cnt;
  logic [1:0] state_dbg;

  prbs_bit_source #(
    .DATA_W(8), .FRAME_LEN(2), .CHIP_RATIO(CR), .SEED(16'hACE1)
  ) dut (
    .clk31(clk31), .rst(rst), .send_ena(send_ena), .insource_ena(insource_ena),
    .loop(loop), .mode(mode), .pattern(pattern), .in_data(in_data),
    .bit_strobe(bit_strobe), .word_start(word_start), .frame_done(frame_done),
    .word_cnt(word_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk31 = ~clk31;

  int checks = 0;
  int errors = 0;

  logic cap_bits[64];
  int   cap_cyc[64];
  int   cap_wc[64];
  int   n_bits, n_done, n_ws, hold_err;
  int   done_cyc[2];
  int   ws_cyc[8];
  int   ws_wc[8];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] pattern;
    logic [7:0] w0;
    logic [7:0] w1;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk31);
    #1;
  endtask

  task automatic go_idle();
    send_ena = 1'b0;
    insource_ena = 1'b0;
    step(2);
  endtask

  function automatic logic [7:0] get_word(input int base);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < 8; i++) w = {w[6:0], cap_bits[base + i]};
    return w;
  endfunction

  // Cycle c is sampled just after edge S+c, where S is the first edge inside the task.
  task automatic capture(input int max_cyc, input int pause_at, input int pause_len, input int frames);
    logic last;
    n_bits = 0; n_done = 0; n_ws = 0; hold_err = 0;
    done_cyc[0] = -1; done_cyc[1] = -1;
    last = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step(1);
      if (bit_strobe) begin
        if (n_bits < 64) begin
          cap_bits[n_bits] = in_data;
          cap_cyc[n_bits] = c;
          cap_wc[n_bits] = int'(word_cnt);
        end
        n_bits++;
        last = in_data;
      end else if (!frame_done && in_data !== last) begin
        hold_err++;
      end
      if (word_start) begin
        if (n_ws < 8) begin
          ws_cyc[n_ws] = c;
          ws_wc[n_ws] = int'(word_cnt);
        end
        n_ws++;
      end
      if (frame_done) begin
        if (n_done < 2) done_cyc[n_done] = c;
        n_done++;
      end
      if (c == pause_at) insource_ena = 1'b0;
      if (c == pause_at + pause_len) insource_ena = 1'b1;
      if (n_done >= frames) break;
    end
  endtask

  task automatic begin_frame(input logic [1:0] m, input logic [7:0] p, input logic lp);
    go_idle();
    mode = m;
    pattern = p;
    loop = lp;
    send_ena = 1'b1;
    insource_ena = 1'b1;
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, pattern: 8'h00, w0: 8'hAC, w1: 8'h59};
    vecs[1] = '{mode: 2'd1, pattern: 8'hFF, w0: 8'h00, w1: 8'h00};
    vecs[2] = '{mode: 2'd2, pattern: 8'hFF, w0: 8'h55, w1: 8'h55};
    vecs[3] = '{mode: 2'd3, pattern: 8'hA5, w0: 8'hA5, w1: 8'hA5};
    vecs[4] = '{mode: 2'd3, pattern: 8'h3C, w0: 8'h3C, w1: 8'h3C};

    // Reset values
    step(2);
    chk("rst_in_data", in_data, 0);
    chk("rst_bit_strobe", bit_strobe, 0);
    chk("rst_word_start", word_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    step(1);

    // Single frames, loop off
    for (int v = 0; v < 5; v++) begin
      begin_frame(vecs[v].mode, vecs[v].pattern, 1'b0);
      capture(FC + 10, -1, 0, 1);
      chk($sformatf("v%0d_start_cyc", v), cap_cyc[0], 0);
      chk($sformatf("v%0d_word0", v), get_word(0), vecs[v].w0);
      chk($sformatf("v%0d_word1", v), get_word(8), vecs[v].w1);
      chk($sformatf("v%0d_nbits", v), n_bits, FB);
      chk($sformatf("v%0d_last_bit_cyc", v), cap_cyc[FB-1], (FB - 1) * CR);
      chk($sformatf("v%0d_done_cyc", v), done_cyc[0], FC);
      chk($sformatf("v%0d_hold", v), hold_err, 0);
      chk($sformatf("v%0d_n_word_start", v), n_ws, 2);
      chk($sformatf("v%0d_wc0", v), cap_wc[0], 0);
      chk($sformatf("v%0d_wc1", v), cap_wc[8], 1);
      chk($sformatf("v%0d_done_busy", v), busy, 0);
      chk($sformatf("v%0d_done_in_data", v), in_data, 0);
      step(3);
      chk($sformatf("v%0d_done_state", v), state_dbg, ST_DONE);
      chk($sformatf("v%0d_done_quiet", v), {busy, frame_done, in_data}, 3'b000);
    end

`ifdef PRBS_SRC_CRC8_EN
    // CRC trailer: data 0x01 0x01 gives CRC-8 0x12
    begin_frame(2'd3, 8'h01, 1'b0);
    capture(FC + 10, -1, 0, 1);
    chk("crc_word0", get_word(0), 8'h01);
    chk("crc_word1", get_word(8), 8'h01);
    chk("crc_trailer", get_word(16), 8'h12);
    chk("crc_done_cyc", done_cyc[0], 24 * CR);
    chk("crc_wc_hold", cap_wc[16], 1);
    chk("crc_n_word_start", n_ws, 2);
`endif

    // Loop mode: back-to-back frames, reseeded PRBS
    begin_frame(2'd0, 8'h00, 1'b1);
    capture(2 * FC + 10, -1, 0, 2);
    chk("loop_done0", done_cyc[0], FC);
    chk("loop_done1", done_cyc[1], 2 * FC);
    chk("loop_f2_word0", get_word(FB), 8'hAC);
    chk("loop_f2_word1", get_word(FB + 8), 8'h59);
    chk("loop_f2_start_cyc", cap_cyc[FB], FC);
    chk("loop_ws2_cyc", ws_cyc[2], FC);
    chk("loop_ws2_wc", ws_wc[2], 0);
    chk("loop_ws3_wc", ws_wc[3], 1);
    chk("loop_hold", hold_err, 0);
    chk("loop_busy", busy, 1);

    // Pause at chip 10 of bit 3 for 50 cycles
    begin_frame(2'd0, 8'h00, 1'b0);
    capture(FC + 60, 3 * CR + 10, 50, 1);
    chk("pause_word0", get_word(0), 8'hAC);
    chk("pause_word1", get_word(8), 8'h59);
    chk("pause_bit3_len", cap_cyc[4] - cap_cyc[3], CR + 50);
    chk("pause_bit4_len", cap_cyc[5] - cap_cyc[4], CR);
    chk("pause_done_cyc", done_cyc[0], FC + 50);
    chk("pause_hold", hold_err, 0);

    // Abort mid-word with both enables dropped together
    begin_frame(2'd0, 8'h00, 1'b0);
    step(71);
    chk("abort_pre_in_data", in_data, 1);
    send_ena = 1'b0;
    insource_ena = 1'b0;
    step(1);
    chk("abort_in_data", in_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_word_cnt", word_cnt, 0);
    chk("abort_state", state_dbg, ST_IDLE);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (frame_done) n_done++;
    end
    chk("abort_no_frame_done", n_done, 0);
    send_ena = 1'b1;
    insource_ena = 1'b1;
    capture(FC + 10, -1, 0, 1);
    chk("abort_restart_word0", get_word(0), 8'hAC);
    chk("abort_restart_done", done_cyc[0], FC);

    // Asynchronous reset between edges mid-frame
    begin_frame(2'd0, 8'h00, 1'b0);
    step(301);
    chk("rstmid_pre_in_data", in_data, 1);
    chk("rstmid_pre_word_cnt", word_cnt, 1);
    #3 rst = 1'b1;
    #1;
    chk("rstmid_in_data", in_data, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_word_cnt", word_cnt, 0);
    chk("rstmid_state", state_dbg, ST_IDLE);
    step(2);
    rst = 1'b0;
    capture(FC + 10, -1, 0, 1);
    chk("rstmid_restart_word0", get_word(0), 8'hAC);
    chk("rstmid_restart_word1", get_word(8), 8'h59);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
